// File: rtl/alu_result_tx.sv
// Serializes one captured ALU result word into bytes (LSB first) over a tx_start/tx_done handshake.
// Optional trailing XOR checksum byte when RESULT_CHECKSUM_EN is defined.
module alu_result_tx #(
    parameter int BUS = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [BUS-1:0] result,
    input  logic           result_valid,
    output logic           ready,
    output logic [7:0]     tx_data,
    output logic           tx_start,
    input  logic           tx_done,
    output logic           sent
);

    localparam int NBYTES = BUS / 8;
    localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

`ifdef RESULT_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, SEND, WAIT, CHK, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, SEND, WAIT, DONE} state_t;
`endif

    state_t         state, next_state;
    logic [BUS-1:0] shreg;
    logic [CW-1:0]  cnt;
    logic           last_byte;

`ifdef RESULT_CHECKSUM_EN
    logic [7:0] csum;
    // Set once the checksum byte has been issued, so WAIT knows the next tx_done ends the frame.
    logic       chk_phase;
`endif

    assign last_byte = (cnt == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
`ifdef RESULT_CHECKSUM_EN
            csum      <= 8'h00;
            chk_phase <= 1'b0;
`endif
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (result_valid) begin
                        shreg <= result;
                        cnt   <= '0;
`ifdef RESULT_CHECKSUM_EN
                        csum      <= 8'h00;
                        chk_phase <= 1'b0;
`endif
                    end
                end
`ifdef RESULT_CHECKSUM_EN
                SEND: csum <= csum ^ shreg[7:0];
                CHK:  chk_phase <= 1'b1;
                WAIT: begin
                    if (tx_done && !last_byte && !chk_phase) begin
                        shreg <= shreg >> 8;
                        cnt   <= cnt + 1'b1;
                    end
                end
`else
                WAIT: begin
                    if (tx_done && !last_byte) begin
                        shreg <= shreg >> 8;
                        cnt   <= cnt + 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        ready      = 1'b0;
        tx_start   = 1'b0;
        sent       = 1'b0;
`ifdef RESULT_CHECKSUM_EN
        tx_data    = chk_phase ? csum : shreg[7:0];
`else
        tx_data    = shreg[7:0];
`endif
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (result_valid) next_state = SEND;
            end
            SEND: begin
                tx_start   = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                if (tx_done) begin
`ifdef RESULT_CHECKSUM_EN
                    if (chk_phase)      next_state = DONE;
                    else if (last_byte) next_state = CHK;
                    else                next_state = SEND;
`else
                    if (last_byte) next_state = DONE;
                    else           next_state = SEND;
`endif
                end
            end
`ifdef RESULT_CHECKSUM_EN
            CHK: begin
                tx_start   = 1'b1;
                tx_data    = csum;
                next_state = WAIT;
            end
`endif
            DONE: begin
                sent       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_result_tx.sv
// Scoreboard bench for alu_result_tx: 32-bit and 16-bit instances, directed vectors.
// Expected checksum bytes are pushed only when RESULT_CHECKSUM_EN is defined.
module tb_alu_result_tx;

    localparam int SENT_MARK = 256;
`ifdef RESULT_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] result;
    logic        result_valid;
    logic        ready;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_done;
    logic        sent;
    logic        resp_en, resp_done, inj_done;

    logic [15:0] result16;
    logic        valid16, ready16, start16, done16, sent16;
    logic [7:0]  data16;

    int total = 0;
    int bad   = 0;
    int nstart = 0;
    int q32[$];
    int q16[$];

    assign tx_done = resp_done | inj_done;

    alu_result_tx #(.BUS(32)) dut (
        .clk(clk), .rst_n(rst_n), .result(result), .result_valid(result_valid),
        .ready(ready), .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done), .sent(sent)
    );

    alu_result_tx #(.BUS(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .result(result16), .result_valid(valid16),
        .ready(ready16), .tx_data(data16), .tx_start(start16), .tx_done(done16), .sent(sent16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // seq lists the four bytes in transmission order, first byte in the top octet.
    task automatic expect32(input logic [31:0] seq, input logic [7:0] cs);
        for (int i = 0; i < 4; i++) q32.push_back(int'(seq[31-8*i -: 8]));
        if (CS) q32.push_back(int'(cs));
        q32.push_back(SENT_MARK);
    endtask

    // UART model: answers each tx_start with a tx_done pulse ten cycles later.
    initial begin
        resp_done = 1'b0;
        forever begin
            @(negedge clk);
            if (resp_en && rst_n && tx_start) begin
                repeat (10) @(posedge clk);
                #1 resp_done = 1'b1;
                @(posedge clk);
                #1 resp_done = 1'b0;
            end
        end
    end

    initial begin
        done16 = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && start16) begin
                repeat (3) @(posedge clk);
                #1 done16 = 1'b1;
                @(posedge clk);
                #1 done16 = 1'b0;
            end
        end
    end

    // Monitors: pop the expected byte or completion marker on every DUT output event.
    always @(negedge clk) begin
        if (rst_n && tx_start) begin
            nstart++;
            if (q32.size() == 0) check("spurious_byte32", q32.size(), 1);
            else                 check("byte32", {24'h0, tx_data}, q32.pop_front());
        end
        if (rst_n && sent) begin
            if (q32.size() == 0) check("spurious_sent32", q32.size(), 1);
            else                 check("sent32", q32.pop_front(), SENT_MARK);
        end
    end

    always @(negedge clk) begin
        if (rst_n && start16) begin
            if (q16.size() == 0) check("spurious_byte16", q16.size(), 1);
            else                 check("byte16", {24'h0, data16}, q16.pop_front());
        end
        if (rst_n && sent16) begin
            if (q16.size() == 0) check("spurious_sent16", q16.size(), 1);
            else                 check("sent16", q16.pop_front(), SENT_MARK);
        end
    end

    task automatic wait_ready();
        int found = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ready) begin found = 1; break; end
        end
        if (found == 0) check("ready_timeout", found, 1);
    endtask

    task automatic wait_start();
        int found = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx_start) begin found = 1; break; end
        end
        check("start_seen", found, 1);
    endtask

    // Returns at the negedge of the cycle after sent, where the block must be idle again.
    task automatic wait_sent();
        int found = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sent) begin found = 1; break; end
        end
        check("sent_seen", found, 1);
        @(negedge clk);
        check("sent_one_cycle", sent, 0);
        check("ready_after_sent", ready, 1);
    endtask

    task automatic pulse_done();
        @(posedge clk);
        #1 inj_done = 1'b1;
        @(posedge clk);
        #1 inj_done = 1'b0;
    endtask

    initial begin
        int base;
        rst_n = 1'b0; result = '0; result_valid = 1'b0; inj_done = 1'b0; resp_en = 1'b1;
        result16 = '0; valid16 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_tx_start", tx_start, 0);
        check("rst_sent", sent, 0);
        check("rst_tx_data", {24'h0, tx_data}, 32'h0);
        check("rst_ready16", ready16, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single result
        expect32(32'h78563412, 8'h08);
        wait_ready();
        @(posedge clk); #1 result = 32'h12345678; result_valid = 1'b1;
        @(posedge clk); #1 result_valid = 1'b0;
        @(negedge clk);
        check("busy_after_capture", ready, 0);
        wait_sent();

        // Held valid with result changed mid-transfer; recapture only after ready
        expect32(32'h78563412, 8'h08);
        expect32(32'hFFFFFFFF, 8'h00);
        @(posedge clk); #1 result = 32'h12345678; result_valid = 1'b1;
        @(posedge clk);
        repeat (15) @(posedge clk);
        #1 result = 32'hFFFFFFFF;
        @(negedge clk);
        check("busy_mid_transfer", ready, 0);
        wait_sent();
        @(posedge clk); #1 result_valid = 1'b0;
        wait_sent();

        // Back-to-back results
        expect32(32'hAA000000, 8'hAA);
        expect32(32'h00BB0000, 8'hBB);
        @(posedge clk); #1 result = 32'h000000AA; result_valid = 1'b1;
        @(posedge clk); #1 result = 32'h0000BB00;
        wait_sent();
        @(posedge clk); #1 result_valid = 1'b0;
        wait_sent();

        // tx_done in IDLE and coincident with tx_start is ignored
        resp_en = 1'b0;
        @(posedge clk); #1 inj_done = 1'b1;
        repeat (3) @(posedge clk);
        #1 inj_done = 1'b0;
        base = nstart;
        repeat (3) @(posedge clk);
        #1 check("idle_done_ignored", nstart, base);
        expect32(32'h0DF0FECA, 8'hC9);
        result = 32'hCAFEF00D; result_valid = 1'b1;
        @(posedge clk); #1 result_valid = 1'b0; inj_done = 1'b1;
        @(posedge clk); #1 inj_done = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("start_done_ignored", nstart, base + 1);
        for (int k = 0; k < 3 + int'(CS); k++) begin
            pulse_done();
            wait_start();
        end
        pulse_done();
        wait_sent();

        // Reset after the second byte's tx_start aborts the transfer
        q32.push_back(32'h78);
        q32.push_back(32'h56);
        @(posedge clk); #1 result = 32'h12345678; result_valid = 1'b1;
        @(posedge clk); #1 result_valid = 1'b0;
        wait_start();
        pulse_done();
        wait_start();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("abort_tx_start", tx_start, 0);
        check("abort_sent", sent, 0);
        check("abort_ready", ready, 1);
        check("abort_queue", q32.size(), 0);
        pulse_done();
        repeat (3) @(posedge clk);
        #1 resp_en = 1'b1;
        expect32(32'h78563412, 8'h08);
        result = 32'h12345678; result_valid = 1'b1;
        @(posedge clk); #1 result_valid = 1'b0;
        wait_sent();

        // 16-bit instance
        q16.push_back(32'hEF);
        q16.push_back(32'hBE);
        if (CS) q16.push_back(32'h51);
        q16.push_back(SENT_MARK);
        @(posedge clk); #1 result16 = 16'hBEEF; valid16 = 1'b1;
        @(posedge clk); #1 valid16 = 1'b0;
        begin
            int found = 0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (sent16) begin found = 1; break; end
            end
            check("sent16_seen", found, 1);
        end
        @(negedge clk);
        check("ready16_after_sent", ready16, 1);

        repeat (5) @(posedge clk);
        check("q32_drained", q32.size(), 0);
        check("q16_drained", q16.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_result_tx.md
Name: alu_result_tx

Overview:
Return path of the UART arithmetic unit. Captures one ALU result word and serializes it into bytes, LSB first, to the UART transmitter using a start/done handshake. Sits between the ALU output and the UART TX byte interface. Signals completion so the operand/control logic can accept the next operation.

Parameters:
BUS, 32, result width in bits; must be a multiple of 8 and at least 8
NBYTES, BUS/8, number of data bytes per result; derived, not overridden

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous reset, active-low
result  input  BUS  ALU result word
result_valid  input  1  result is valid; captured when ready=1
ready  output  1  block idle and able to capture a result
tx_data  output  8  byte to UART TX
tx_start  output  1  one-cycle pulse requesting transmission of tx_data
tx_done  input  1  one-cycle pulse from UART TX: current byte fully sent
sent  output  1  one-cycle pulse after the last byte's tx_done

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE; ready=1; tx_start=0; sent=0; tx_data=8'h00; shift register and byte counter cleared.
- Reset mid-transfer aborts the transfer. The remaining bytes are dropped and no sent pulse is issued.
- FSM states: IDLE, SEND, WAIT, CHK (only with the optional feature), DONE.
- IDLE: ready=1.
  - result_valid=1: latch result into the shift register; counter=0; go to SEND; ready=0 from the next cycle.
  - result_valid=0: stay in IDLE.
- SEND: tx_start=1 for exactly this cycle; tx_data=shreg[7:0]. Go to WAIT next cycle.
- WAIT: tx_start=0; tx_data held stable.
  - tx_done=1 and counter=NBYTES-1: go to DONE (or CHK if enabled).
  - tx_done=1 otherwise: shift register shifts right by 8; counter+1; go to SEND.
  - tx_done=0: stay in WAIT, no timeout.
- DONE: sent=1 for one cycle; go to IDLE. ready=1 in the following cycle.
- Latency:
  - Capture to first tx_start: 1 cycle.
  - tx_done to next tx_start: 1 cycle.
  - Last tx_done to sent: 1 cycle.
  - Back-to-back results: the minimum gap between sent and the next capture is 1 cycle.
- result_valid while ready=0 is ignored; the result is not queued.
- tx_done outside WAIT (IDLE, SEND, DONE) is ignored. This includes tx_done in the same cycle as tx_start.
- result is sampled only at capture; later changes have no effect.
- The counter never wraps past NBYTES-1. The byte order is always byte 0 (bits 7:0) first.

Optional Feature:
Macro RESULT_CHECKSUM_EN.
- Defined:
  - The block keeps a running XOR of all data bytes sent, cleared at capture.
  - After the last data byte's tx_done, the FSM enters CHK: tx_start pulse with tx_data=XOR value, then wait for tx_done.
  - The FSM then goes to DONE. The transfer is NBYTES+1 bytes.
- Not defined: no CHK state or XOR register; WAIT goes directly to DONE after the last byte.

Test Plan:
- BUS=32, result=0x12345678, tx_done returned 10 cycles after each tx_start -> tx_data 0x78, 0x56, 0x34, 0x12 on four tx_start pulses; one sent pulse; ready=1 afterwards. With RESULT_CHECKSUM_EN, a fifth byte 0x08 is sent, then sent.
- result_valid held high while busy, with result changed to 0xFFFFFFFF mid-transfer -> bytes of the original 0x12345678 only; second value not sent; recaptured only once ready=1.
- Back-to-back: 0x000000AA then 0x0000BB00 presented on the cycle ready returns -> 8 bytes AA,00,00,00,00,BB,00,00; two sent pulses.
- tx_done pulses injected in IDLE and in the same cycle as tx_start -> ignored; the byte count advances only on tx_done in WAIT.
- rst_n low for 1 cycle after the second byte's tx_start -> tx_start=0, sent=0, ready=1 the next cycle; no further bytes sent; a new capture then starts with byte 0.
- BUS=16, result=0xBEEF -> bytes 0xEF, 0xBE, then sent (checksum 0x51 when enabled).
